// File: rtl/riscv_mem_pkg.sv
// Encodings shared by the riscv_processor memory-port arbiter and its priority
// selector.
package riscv_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int DEFAULT_MEM_LATENCY  = 2;
    localparam int DEFAULT_STARVE_LIMIT = 3;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and load/store: LS wins unless IF is alone or
// the LS streak has reached its limit.
module mem_arb_prio
    import riscv_mem_pkg::*;
(
    input  logic   if_req_i,
    input  logic   ls_req_i,
    input  logic   streak_full_i,
    output logic   valid_o,
    output owner_e winner_o
);

    always_comb begin
        valid_o  = if_req_i | ls_req_i;
        winner_o = OWN_LS;
        if (if_req_i && (!ls_req_i || streak_full_i)) begin
            winner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between fetch and load/store, one outstanding
// access at a time against a fixed-latency memory.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
    localparam int STRK_W = $clog2(STARVE_LIMIT + 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STRK_W-1:0]   streak_q, streak_d;
    logic                we_q, we_d;

    logic   grant_valid;
    owner_e winner;
    logic   streak_full;

    assign streak_full = (streak_q == STRK_W'(STARVE_LIMIT));

    mem_arb_prio u_prio (
        .if_req_i      (if_req_i),
        .ls_req_i      (ls_req_i),
        .streak_full_i (streak_full),
        .valid_o       (grant_valid),
        .winner_o      (winner)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            cnt_q    <= '0;
            streak_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
            we_q     <= we_d;
        end
    end

    // Every output is forced low while reset is asserted, so an access cut
    // short by reset never produces a response.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        we_d        = we_q;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mem_req_o = 1'b1;
                        owner_d   = winner;
                        cnt_d     = CNT_W'(MEM_LATENCY);
                        state_d   = ST_WAIT;
                        if (winner == OWN_LS) begin
                            ls_gnt_o    = 1'b1;
                            mem_we_o    = ls_we_i;
                            mem_be_o    = ls_be_i;
                            mem_addr_o  = ls_addr_i;
                            mem_wdata_o = ls_wdata_i;
                            we_d        = ls_we_i;
                            if (!if_req_i) begin
                                streak_d = '0;
                            end else if (!streak_full) begin
                                streak_d = streak_q + STRK_W'(1);
                            end
                        end else begin
                            if_gnt_o   = 1'b1;
                            mem_be_o   = 4'hF;
                            mem_addr_o = if_addr_i;
                            we_d       = 1'b0;
                            streak_d   = '0;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        if (owner_q == OWN_LS) begin
                            ls_rvalid_o = 1'b1;
                            ls_rdata_o  = we_q ? '0 : mem_rdata_i;
                        end else begin
                            if_rvalid_o = 1'b1;
                            if_rdata_o  = mem_rdata_i;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
